clm_mod_p_reduce: RTL and testbench

- Final-output stage of the CLM cipher datapath; runs in the MOD_P stage, after ADD_ROUND_KEY_LAST and before PREP_OUTPUT.
- Takes the 16-element redundant state (state_vec_t, each element 8+d bits) and reduces every element modulo the run's base polynomial P.
- Delivers a plain 128-bit aes_state_t with a drdy_i/drdy_o handshake.
- Reduction is bit-serial long division: LANES elements are processed in parallel, one division step per cycle.

---
 rtl/clm_mod_p_reduce_pkg.sv | 41 ++++
 rtl/clm_mod_p_reduce_if.sv | 24 ++
 rtl/clm_mod_p_reduce_step.sv | 30 +++
 rtl/clm_mod_p_reduce.sv | 169 ++++++++++++++++
 tb/tb_clm_mod_p_reduce.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clm_mod_p_reduce_pkg.sv
// ============================================================================
// Module : clm_mod_p_reduce_pkg
// Brief  : Shared types, constants and stage encoding for the MOD_P stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clm_mod_p_reduce_pkg;

    // Redundancy degree: every state element carries 8+D coefficients.
    localparam int D               = 4;
    localparam int ELEM_W          = 8 + D;
    localparam int NUM_ELEM        = 16;
    localparam int ELEM_IDX_W      = $clog2(NUM_ELEM);
    localparam int BIT_IDX_W       = $clog2(ELEM_W);
    localparam int K_W             = (D > 1) ? $clog2(D) : 1;
    localparam int MODP_STAGE_BITS = 2;

    // Index 0 is the highest-degree coefficient in every polynomial type.
    typedef logic [0:ELEM_W-1]          state_t;
    typedef state_t [0:NUM_ELEM-1]      state_vec_t;
    typedef logic [0:8]                 base_poly_t;
    typedef logic [0:7]                 byte_t;
    typedef byte_t [0:NUM_ELEM-1]       aes_state_t;
    typedef logic [K_W-1:0]             step_idx_t;

    typedef enum logic [MODP_STAGE_BITS-1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } modp_stages_t;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clm_mod_p_reduce_if.sv
// ============================================================================
// Module : clm_mod_p_reduce_if
// Brief  : Start/result handshake bundle between the cipher core and MOD_P.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface clm_mod_p_reduce_if;
    import clm_mod_p_reduce_pkg::*;

    logic       drdy_i;
    state_vec_t in;
    base_poly_t P;
    aes_state_t out;
    logic       drdy_o;
    logic       busy;
    logic       err;

    modport master (output drdy_i, in, P, input out, drdy_o, busy, err);
    modport slave  (input drdy_i, in, P, output out, drdy_o, busy, err);

endinterface

`default_nettype wire

// File: rtl/clm_mod_p_reduce_step.sv
// ============================================================================
// Module : clm_mod_p_step
// Brief  : One GF(2) long-division step: cancel coefficient k with P if set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clm_mod_p_step
    import clm_mod_p_reduce_pkg::*;
(
    input  state_t     i_elem,
    input  step_idx_t  i_k,
    input  base_poly_t i_poly,
    output state_t     o_elem
);

    logic [BIT_IDX_W-1:0] w_pos;

    assign w_pos = BIT_IDX_W'(i_k);

    always_comb begin
        o_elem = i_elem;
        if (i_elem[w_pos]) begin
            o_elem[w_pos +: 9] = i_elem[w_pos +: 9] ^ i_poly;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clm_mod_p_reduce.sv
// ============================================================================
// Module : clm_mod_p_reduce
// Brief  : Bit-serial reduction of the 16-element redundant state modulo P.
//          Optional invalid-P detection built with CLM_MOD_P_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clm_mod_p_reduce
    import clm_mod_p_reduce_pkg::*;
#(
    parameter int LANES = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    clm_mod_p_reduce_if.slave bus
);

    localparam int                c_groups = NUM_ELEM / LANES;
    localparam int                c_g_w    = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam logic [c_g_w-1:0]  c_g_last = c_g_w'(c_groups - 1);
    localparam step_idx_t         c_k_last = K_W'(D - 1);

    generate
        if (!lanes_legal(LANES)) begin : g_lanes_illegal
            $error("clm_mod_p_reduce: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    modp_stages_t           r_state;
    modp_stages_t           w_state_next;
    state_vec_t             r_w;
    base_poly_t             r_preg;
    logic [c_g_w-1:0]       r_g;
    step_idx_t              r_k;
    aes_state_t             r_out;
    logic                   r_drdy_o;
    logic                   w_last_step;
    logic                   w_force_zero;
    aes_state_t             w_packed;
    logic [ELEM_IDX_W-1:0]  w_idx      [LANES];
    state_t                 w_lane_in  [LANES];
    state_t                 w_lane_out [LANES];

    // Lane l of group g works on element g*LANES+l.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_idx[l]     = ELEM_IDX_W'(int'(r_g) * LANES + l);
            assign w_lane_in[l] = r_w[w_idx[l]];

            clm_mod_p_step u_step (
                .i_elem (w_lane_in[l]),
                .i_k    (r_k),
                .i_poly (r_preg),
                .o_elem (w_lane_out[l])
            );
        end
    endgenerate

    assign w_last_step = (r_k == c_k_last) && (r_g == c_g_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.drdy_i) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_REDUCE;
            S_REDUCE: if (w_last_step) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // The remainder sits in coefficients x^7..x^0 once the top D are cancelled.
    always_comb begin
        w_packed = '0;
        for (int e = 0; e < NUM_ELEM; e++) begin
            w_packed[e] = r_w[e][D +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w      <= '0;
            r_preg   <= '0;
            r_g      <= '0;
            r_k      <= '0;
            r_out    <= '0;
            r_drdy_o <= 1'b0;
        end else begin
            r_drdy_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.drdy_i) begin
                        r_w    <= bus.in;
                        r_preg <= bus.P;
                    end
                end
                S_LOAD: begin
                    r_g <= '0;
                    r_k <= '0;
                end
                S_REDUCE: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_w[w_idx[l]] <= w_lane_out[l];
                    end
                    if (r_k == c_k_last) begin
                        r_k <= '0;
                        if (!w_last_step) begin
                            r_g <= r_g + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    r_out    <= w_force_zero ? '0 : w_packed;
                    r_drdy_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CLM_MOD_P_CHECK_EN
    logic r_bad;
    logic r_err;

    // A P without its x^8 term cannot reduce to 8 bits; flag it but keep timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.drdy_i) begin
                        r_bad <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                S_LOAD:  r_bad <= ~r_preg[0];
                S_DONE:  r_err <= r_bad;
                default: ;
            endcase
        end
    end

    assign w_force_zero = r_bad;
    assign bus.err      = r_err;
`else
    assign w_force_zero = 1'b0;
    assign bus.err      = 1'b0;
`endif

    assign bus.out    = r_out;
    assign bus.drdy_o = r_drdy_o;
    assign bus.busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_clm_mod_p_reduce.sv
// ============================================================================
// Module : tb_clm_mod_p_reduce
// Brief  : Scoreboard bench for clm_mod_p_reduce at LANES = 4, 1 and 16.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clm_mod_p_reduce;
    import clm_mod_p_reduce_pkg::*;

    typedef struct packed {
        aes_state_t out;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    state_vec_t in_v;
    base_poly_t p_v;
    logic       drdy_v   [3];
    aes_state_t out_v    [3];
    logic       drdy_o_v [3];
    logic       busy_v   [3];
    logic       err_v    [3];
    exp_t       sb_q     [$];
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    clm_mod_p_reduce_if if_l4  ();
    clm_mod_p_reduce_if if_l1  ();
    clm_mod_p_reduce_if if_l16 ();

    assign if_l4.drdy_i  = drdy_v[0];
    assign if_l1.drdy_i  = drdy_v[1];
    assign if_l16.drdy_i = drdy_v[2];
    assign if_l4.in  = in_v;  assign if_l4.P  = p_v;
    assign if_l1.in  = in_v;  assign if_l1.P  = p_v;
    assign if_l16.in = in_v;  assign if_l16.P = p_v;
    assign out_v[0] = if_l4.out;  assign drdy_o_v[0] = if_l4.drdy_o;
    assign busy_v[0] = if_l4.busy; assign err_v[0] = if_l4.err;
    assign out_v[1] = if_l1.out;  assign drdy_o_v[1] = if_l1.drdy_o;
    assign busy_v[1] = if_l1.busy; assign err_v[1] = if_l1.err;
    assign out_v[2] = if_l16.out; assign drdy_o_v[2] = if_l16.drdy_o;
    assign busy_v[2] = if_l16.busy; assign err_v[2] = if_l16.err;

    clm_mod_p_reduce #(.LANES(4))  u_dut_l4  (.clk(clk), .rst_n(rst_n), .bus(if_l4));
    clm_mod_p_reduce #(.LANES(1))  u_dut_l1  (.clk(clk), .rst_n(rst_n), .bus(if_l1));
    clm_mod_p_reduce #(.LANES(16)) u_dut_l16 (.clk(clk), .rst_n(rst_n), .bus(if_l16));

    function automatic int lat_of(input int w);
        int lanes;
        lanes = (w == 0) ? 4 : ((w == 1) ? 1 : 16);
        return 2 + (NUM_ELEM / lanes) * D;
    endfunction

    // Polynomial long division with x^0 as the numeric LSB.
    function automatic logic [7:0] ref_reduce(input state_t x, input base_poly_t p);
        logic [ELEM_W-1:0] v;
        logic [ELEM_W-1:0] pp;
        v  = x;
        pp = ELEM_W'(p);
        for (int i = ELEM_W - 1; i >= 8; i--) begin
            if (v[i]) v = v ^ (pp << (i - 8));
        end
        return v[7:0];
    endfunction

    function automatic exp_t model(input state_vec_t v, input base_poly_t p);
        exp_t       e;
        logic [8:0] pn;
        pn    = p;
        e.err = 1'b0;
        for (int i = 0; i < NUM_ELEM; i++) e.out[i] = ref_reduce(v[i], p);
`ifdef CLM_MOD_P_CHECK_EN
        if (!pn[8]) begin
            e.out = '0;
            e.err = 1'b1;
        end
`else
        if (!pn[8]) e.err = 1'b0;
`endif
        return e;
    endfunction

    function automatic state_vec_t fill(input state_t x);
        state_vec_t v;
        for (int i = 0; i < NUM_ELEM; i++) v[i] = x;
        return v;
    endfunction

    function automatic state_vec_t rand_vec();
        state_vec_t v;
        for (int i = 0; i < NUM_ELEM; i++) v[i] = ELEM_W'($urandom);
        return v;
    endfunction

    function automatic base_poly_t rand_valid_p();
        return 9'(9'h100 | 9'($urandom_range(0, 255)));
    endfunction

    // Present one vector, push its expected result, then scramble the inputs.
    task automatic start(input int w, input state_vec_t v, input base_poly_t p, input exp_t e);
        in_v      = v;
        p_v       = p;
        drdy_v[w] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        drdy_v[w] = 1'b0;
        in_v      = rand_vec();
        p_v       = 9'($urandom);
    endtask

    task automatic wait_done(input int w, input string name, input bit repulse);
        int   n;
        int   nb;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        nb   = busy_v[w] ? 1 : 0;
        while (!seen && n < 200) begin
            drdy_v[w] = repulse && (n == 4 || n == 16 || n == 17);
            @(posedge clk); #1;
            n++;
            if (drdy_o_v[w]) seen = 1'b1;
            else if (busy_v[w]) nb++;
        end
        drdy_v[w] = 1'b0;
        n_vec++;
        if (!seen || n !== lat_of(w)) begin
            n_miss++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, n, seen, lat_of(w));
        end
        n_vec++;
        if (nb !== lat_of(w)) begin
            n_miss++;
            $display("FAIL %s busy_len: got %0d cycles, expected %0d", name, nb, lat_of(w));
        end
        if (sb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            n_vec++;
            if (out_v[w] !== e.out) begin
                n_miss++;
                $display("FAIL %s out: got %h expected %h", name, out_v[w], e.out);
            end
            n_vec++;
            if (err_v[w] !== e.err) begin
                n_miss++;
                $display("FAIL %s err: got %b expected %b", name, err_v[w], e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            n_vec++;
            if ({out_v[w], drdy_o_v[w], busy_v[w], err_v[w]} !== '0) begin
                n_miss++;
                $display("FAIL reset_state[%0d]: got out=%h drdy_o=%b busy=%b err=%b expected all 0",
                         w, out_v[w], drdy_o_v[w], busy_v[w], err_v[w]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_value();
        exp_t e;
        e.out = {16{8'h1B}};
        e.err = 1'b0;
        start(0, fill(12'h100), 9'h11B, e);
        wait_done(0, "all_100", 1'b0);
        @(posedge clk); #1;
        n_vec++;
        if (drdy_o_v[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL drdy_o_pulse: got %b expected 0", drdy_o_v[0]);
        end
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (out_v[0] !== e.out) begin
            n_miss++;
            $display("FAIL out_hold: got %h expected %h", out_v[0], e.out);
        end
    endtask

    task automatic test_sparse();
        state_vec_t v;
        exp_t       e;
        v      = '0;
        v[0]   = 12'hFFF;
        v[15]  = 12'h0AB;
        e.out  = '0;
        e.out[0]  = 8'h66;
        e.out[15] = 8'hAB;
        e.err  = 1'b0;
        start(0, v, 9'h11B, e);
        wait_done(0, "sparse", 1'b0);
    endtask

    task automatic test_repulse();
        state_vec_t v;
        int         extra;
        v = rand_vec();
        start(0, v, 9'h11B, model(v, 9'h11B));
        wait_done(0, "repulse", 1'b1);
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (drdy_o_v[0]) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_miss++;
            $display("FAIL repulse_extra_drdy_o: got %0d pulses expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        state_vec_t v;
        base_poly_t p;
        for (int r = 0; r < 3; r++) begin
            v = rand_vec();
            p = rand_valid_p();
            start(0, v, p, model(v, p));
            wait_done(0, "back_to_back", 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        e.out = {16{8'h1B}};
        e.err = 1'b0;
        start(0, rand_vec(), 9'h11B, e);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_v[0], busy_v[0], drdy_o_v[0]} !== '0) begin
            n_miss++;
            $display("FAIL reset_mid_run: got out=%h busy=%b drdy_o=%b expected all 0",
                     out_v[0], busy_v[0], drdy_o_v[0]);
        end
        e = sb_q.pop_back();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start(0, fill(12'h100), 9'h11B, e);
        wait_done(0, "after_reset", 1'b0);
    endtask

    task automatic test_lane_widths();
        state_vec_t v;
        base_poly_t p;
        exp_t       e;
        e.out = {16{8'h1B}};
        e.err = 1'b0;
        for (int w = 1; w < 3; w++) begin
            start(w, fill(12'h100), 9'h11B, e);
            wait_done(w, (w == 1) ? "lanes1_100" : "lanes16_100", 1'b0);
            v = rand_vec();
            p = rand_valid_p();
            start(w, v, p, model(v, p));
            wait_done(w, (w == 1) ? "lanes1_rand" : "lanes16_rand", 1'b0);
        end
    endtask

    task automatic test_p_check();
        state_vec_t v;
        for (int w = 0; w < 3; w += 2) begin
            v = rand_vec();
            start(w, v, 9'h081, model(v, 9'h081));
            wait_done(w, "bad_p", 1'b0);
            v = rand_vec();
            start(w, v, 9'h11B, model(v, 9'h11B));
            wait_done(w, "bad_p_recover", 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_v  = '0;
        p_v   = '0;
        for (int w = 0; w < 3; w++) drdy_v[w] = 1'b0;
        test_reset();
        test_single_value();
        test_sparse();
        test_repulse();
        test_back_to_back();
        test_reset_mid_run();
        test_lane_widths();
        test_p_check();
        n_vec++;
        if (sb_q.size() !== 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
